point_feeder: RTL and testbench
===============================

Name: point_feeder

Overview:
- Data-source end of the regression datapath's point interface.
- Stores up to N (x, y) sample points written by a loader, then streams them one per `ld` pulse to the coefficient calculator.
- Supports repeated full passes: the mean pass, then the coefficient pass.
- Presents the current point combinationally-stable on registered outputs before each `ld`, and flags the last point and pass completion.

Parameters:
- N, 150, maximum number of stored points.
- DW, 20, width of each x and y sample (two's complement).
- CW, 8, width of pointer/count; must satisfy 2^CW > N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clear  in  1  empty the dataset; highest priority
- wrEn  in  1  append (wrX, wrY) as next point
- wrX  in  DW  sample x to store
- wrY  in  DW  sample y to store
- full  out  1  count == N
- count  out  CW  number of stored points
- passStart  in  1  begin/restart a pass at point 0
- ld  in  1  consumer has taken current point; advance
- xOut  out  DW  x of current point
- yOut  out  DW  y of current point
- valid  out  1  xOut/yOut hold a streamable point (state STREAM)
- lastPoint  out  1  current point index == count-1 while valid
- passDone  out  1  one-cycle pulse after last point consumed
- busy  out  1  state == STREAM

Behaviour:
- Reset (rst low, async):
  - state=LOAD; count=0; rdPtr=0.
  - xOut=0, yOut=0; valid, lastPoint, passDone, busy = 0; full=0.
- Storage: N-entry register array; not reset.
- States:
  - LOAD, ARMED: writes accepted.
  - STREAM: points presented.
- Write rules:
  - In LOAD/ARMED, wrEn && !full stores at index count; count++ next edge.
  - wrEn when full, or in STREAM: ignored, no state change.
- Pass start:
  - In LOAD/ARMED, passStart with count>0 (after including any same-cycle write) → STREAM, rdPtr=0.
  - passStart with count==0 is ignored.
  - passStart in STREAM aborts and restarts at rdPtr=0; no passDone.
- Output timing:
  - xOut/yOut/lastPoint are registered.
  - On the edge entering STREAM or advancing rdPtr, outputs load mem[new rdPtr]; valid in the same cycle the pointer changes.
  - Consumer may sample on any cycle with valid=1.
- ld handling:
  - In STREAM with rdPtr < count-1: rdPtr++.
  - In STREAM with rdPtr == count-1: → ARMED; valid=0; passDone=1 for exactly one cycle; xOut/yOut hold last point.
- Pass length: a 1-point dataset gives lastPoint=1 immediately; one ld ends the pass.
- Simultaneous ld and passStart in STREAM: passStart wins (restart at 0).
- clear: from any state → LOAD, count=0, rdPtr=0, valid=0; overrides wrEn/passStart/ld the same cycle.
- full is combinational from count.
- Reset asserted mid-pass: immediate return to reset values; dataset contents are considered lost (count=0).
- Arithmetic: rdPtr and count are unsigned CW-bit values; no wrap, since bounded by N.

Optional Feature:
- Macro FEEDER_OVERRUN_CHECK_EN.
- Defined:
  - Adds output `overrun` (1 bit, reset 0).
  - overrun sets sticky when ld arrives while not in STREAM, or wrEn while full or in STREAM.
  - Cleared by clear or by an accepted passStart.
- Undefined: port absent; such events are silently ignored as above.

Decomposition:
- Shared package/header holds:
  - state encodings FEEDER_LOAD, FEEDER_ARMED, FEEDER_STREAM (2-bit);
  - defaults for N, DW, CW shared with the calculator.
- One natural sub-module, point_store: N×2·DW register array with write port (index, data) and combinational read port.
- The FSM and pointers stay in point_feeder.

Test Plan:
- Load 3 points (1,2),(3,4),(5,6); pulse passStart → next cycle valid=1, xOut=1, yOut=2, lastPoint=0; after 2 ld pulses lastPoint=1 with (5,6); third ld → passDone pulse 1 cycle, valid=0, busy=0.
- Same dataset, second passStart after passDone → stream restarts at (1,2); count stays 3.
- Write 150 points → full=1, count=150; 151st wrEn ignored (count stays 150; overrun=1 if macro defined).
- Mid-stream (rdPtr=1) assert passStart together with ld → xOut returns to point 0, no passDone.
- Pull rst low mid-pass at rdPtr=2 → all outputs 0 immediately, count=0; passStart afterward ignored until a write occurs.
- passStart with count=0, and ld in ARMED → no state change, valid stays 0; overrun=1 only with the macro, cleared by clear.

Source files
------------

// File: rtl/point_feeder_pkg.sv
// Shared types and default sizing for the regression point interface.
// Optional overrun flag: FEEDER_OVERRUN_CHECK_EN.
package point_feeder_pkg;

    localparam int FEEDER_N  = 150;
    localparam int FEEDER_DW = 20;
    localparam int FEEDER_CW = 8;

    typedef enum logic [1:0] {
        FEEDER_LOAD   = 2'd0,
        FEEDER_ARMED  = 2'd1,
        FEEDER_STREAM = 2'd2
    } feederState_t;

endpackage

// File: rtl/point_store.sv
// N-entry (x, y) sample array: one write port, one combinational read port.
// Contents are deliberately not reset.
module point_store
    import point_feeder_pkg::*;
#(
    parameter int N  = FEEDER_N,
    parameter int DW = FEEDER_DW,
    parameter int CW = FEEDER_CW
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [CW-1:0] wrIdx,
    input  logic [DW-1:0] wrX,
    input  logic [DW-1:0] wrY,
    input  logic [CW-1:0] rdIdx,
    output logic [DW-1:0] rdX,
    output logic [DW-1:0] rdY
);

    logic [2*DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wrEn && (wrIdx < CW'(N))) begin
            mem[wrIdx] <= {wrX, wrY};
        end
    end

    // Look-ahead index can reach N on the final point; read zero there.
    always_comb begin
        rdX = '0;
        rdY = '0;
        if (rdIdx < CW'(N)) begin
            {rdX, rdY} = mem[rdIdx];
        end
    end

endmodule

// File: rtl/point_feeder.sv
// Loads up to N points, then streams them one per ld for repeated passes.
// Optional sticky overrun output: FEEDER_OVERRUN_CHECK_EN.
module point_feeder
    import point_feeder_pkg::*;
#(
    parameter int N  = FEEDER_N,
    parameter int DW = FEEDER_DW,
    parameter int CW = FEEDER_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          wrEn,
    input  logic [DW-1:0] wrX,
    input  logic [DW-1:0] wrY,
    output logic          full,
    output logic [CW-1:0] count,
    input  logic          passStart,
    input  logic          ld,
    output logic [DW-1:0] xOut,
    output logic [DW-1:0] yOut,
    output logic          valid,
    output logic          lastPoint,
    output logic          passDone,
    output logic          busy
`ifdef FEEDER_OVERRUN_CHECK_EN
    ,
    output logic          overrun
`endif
);

    feederState_t  state;
    logic [CW-1:0] rdPtr;

    logic          streaming;
    logic          wrOk;
    logic [CW-1:0] cntNext;
    logic [CW-1:0] lastIdx;
    logic [CW-1:0] nxtPtr;
    logic          startOk;
    logic          atLast;
    logic [CW-1:0] rdIdx;
    logic [DW-1:0] rdX;
    logic [DW-1:0] rdY;
    logic          useWr;
    logic [DW-1:0] nxtX;
    logic [DW-1:0] nxtY;

    assign streaming = (state == FEEDER_STREAM);
    assign full      = (count == CW'(N));
    assign valid     = streaming;
    assign busy      = streaming;

    assign wrOk    = wrEn && !full && !streaming;
    assign cntNext = count + CW'(wrOk);
    assign lastIdx = count - CW'(1);
    assign nxtPtr  = rdPtr + CW'(1);
    assign startOk = passStart && (streaming || (cntNext != '0));
    assign atLast  = (rdPtr == lastIdx);
    assign rdIdx   = startOk ? '0 : nxtPtr;

    // Starting a pass on the same edge as the very first write: bypass.
    assign useWr = wrOk && (count == '0);
    assign nxtX  = useWr ? wrX : rdX;
    assign nxtY  = useWr ? wrY : rdY;

    point_store #(
        .N (N),
        .DW(DW),
        .CW(CW)
    ) u_store (
        .clk  (clk),
        .wrEn (wrOk && !clear),
        .wrIdx(count),
        .wrX  (wrX),
        .wrY  (wrY),
        .rdIdx(rdIdx),
        .rdX  (rdX),
        .rdY  (rdY)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FEEDER_LOAD;
            count     <= '0;
            rdPtr     <= '0;
            xOut      <= '0;
            yOut      <= '0;
            lastPoint <= 1'b0;
            passDone  <= 1'b0;
        end else begin
            passDone <= 1'b0;
            if (clear) begin
                state     <= FEEDER_LOAD;
                count     <= '0;
                rdPtr     <= '0;
                lastPoint <= 1'b0;
            end else begin
                if (wrOk) begin
                    count <= cntNext;
                end
                if (startOk) begin
                    state     <= FEEDER_STREAM;
                    rdPtr     <= '0;
                    xOut      <= nxtX;
                    yOut      <= nxtY;
                    lastPoint <= (cntNext == CW'(1));
                end else if (streaming && ld) begin
                    if (atLast) begin
                        state     <= FEEDER_ARMED;
                        lastPoint <= 1'b0;
                        passDone  <= 1'b1;
                    end else begin
                        rdPtr     <= nxtPtr;
                        xOut      <= rdX;
                        yOut      <= rdY;
                        lastPoint <= (nxtPtr == lastIdx);
                    end
                end
            end
        end
    end

`ifdef FEEDER_OVERRUN_CHECK_EN
    logic misuse;

    assign misuse = (ld && !streaming) ||
                    (wrEn && (full || streaming));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (clear || startOk) begin
            overrun <= 1'b0;
        end else if (misuse) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_point_feeder.sv
// Directed bench for point_feeder: load, stream, restart, abort, reset, fill.
module tb_point_feeder;

    localparam int N  = 150;
    localparam int DW = 20;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          wrEn = 1'b0;
    logic [DW-1:0] wrX = '0;
    logic [DW-1:0] wrY = '0;
    logic          full;
    logic [CW-1:0] count;
    logic          passStart = 1'b0;
    logic          ld = 1'b0;
    logic [DW-1:0] xOut;
    logic [DW-1:0] yOut;
    logic          valid;
    logic          lastPoint;
    logic          passDone;
    logic          busy;
`ifdef FEEDER_OVERRUN_CHECK_EN
    logic          overrun;
`endif

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    point_feeder #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wrEn     (wrEn),
        .wrX      (wrX),
        .wrY      (wrY),
        .full     (full),
        .count    (count),
        .passStart(passStart),
        .ld       (ld),
        .xOut     (xOut),
        .yOut     (yOut),
        .valid    (valid),
        .lastPoint(lastPoint),
        .passDone (passDone),
        .busy     (busy)
`ifdef FEEDER_OVERRUN_CHECK_EN
        ,
        .overrun  (overrun)
`endif
    );

    // Drivers: start and end on a negedge with inputs idle.
    task automatic write_pt(input int x, input int y);
        wrEn = 1'b1; wrX = DW'(x); wrY = DW'(y);
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    task automatic pulse_ld();
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic pulse_start();
        passStart = 1'b1;
        @(negedge clk);
        passStart = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nCmp++; if (count !== 8'd0) begin nErr++; $display("FAIL rst_count got %0d want 0", count); end
        nCmp++; if (xOut !== 20'd0 || yOut !== 20'd0) begin nErr++; $display("FAIL rst_xy got %0d,%0d want 0,0", xOut, yOut); end
        nCmp++; if ({valid, lastPoint, passDone, busy, full} !== 5'b0) begin nErr++; $display("FAIL rst_flags got %b want 00000", {valid, lastPoint, passDone, busy, full}); end
`ifdef FEEDER_OVERRUN_CHECK_EN
        nCmp++; if (overrun !== 1'b0) begin nErr++; $display("FAIL rst_overrun got %b want 0", overrun); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        write_pt(1, 2);
        write_pt(3, 4);
        write_pt(5, 6);
        nCmp++; if (count !== 8'd3) begin nErr++; $display("FAIL st_count got %0d want 3", count); end
        nCmp++; if (valid !== 1'b0) begin nErr++; $display("FAIL st_prevalid got %b want 0", valid); end
        pulse_start();
        nCmp++; if ({valid, busy, lastPoint} !== 3'b110) begin nErr++; $display("FAIL st_p0_flags got %b want 110", {valid, busy, lastPoint}); end
        nCmp++; if (xOut !== 20'd1 || yOut !== 20'd2) begin nErr++; $display("FAIL st_p0 got %0d,%0d want 1,2", xOut, yOut); end
        pulse_ld();
        nCmp++; if (xOut !== 20'd3 || yOut !== 20'd4 || lastPoint !== 1'b0) begin nErr++; $display("FAIL st_p1 got %0d,%0d,%b want 3,4,0", xOut, yOut, lastPoint); end
        pulse_ld();
        nCmp++; if (xOut !== 20'd5 || yOut !== 20'd6 || lastPoint !== 1'b1) begin nErr++; $display("FAIL st_p2 got %0d,%0d,%b want 5,6,1", xOut, yOut, lastPoint); end
        nCmp++; if (passDone !== 1'b0) begin nErr++; $display("FAIL st_earlydone got %b want 0", passDone); end
        pulse_ld();
        nCmp++; if ({passDone, valid, busy} !== 3'b100) begin nErr++; $display("FAIL st_done got %b want 100", {passDone, valid, busy}); end
        nCmp++; if (xOut !== 20'd5 || yOut !== 20'd6) begin nErr++; $display("FAIL st_hold got %0d,%0d want 5,6", xOut, yOut); end
        @(negedge clk);
        nCmp++; if (passDone !== 1'b0) begin nErr++; $display("FAIL st_donepulse got %b want 0", passDone); end
    endtask

    task automatic test_restart_pass();
        pulse_start();
        nCmp++; if (xOut !== 20'd1 || yOut !== 20'd2 || valid !== 1'b1) begin nErr++; $display("FAIL rp_p0 got %0d,%0d,%b want 1,2,1", xOut, yOut, valid); end
        nCmp++; if (count !== 8'd3) begin nErr++; $display("FAIL rp_count got %0d want 3", count); end
    endtask

    task automatic test_abort();
        pulse_ld();
        nCmp++; if (xOut !== 20'd3 || yOut !== 20'd4) begin nErr++; $display("FAIL ab_p1 got %0d,%0d want 3,4", xOut, yOut); end
        passStart = 1'b1; ld = 1'b1;
        @(negedge clk);
        passStart = 1'b0; ld = 1'b0;
        nCmp++; if (xOut !== 20'd1 || yOut !== 20'd2 || valid !== 1'b1) begin nErr++; $display("FAIL ab_restart got %0d,%0d,%b want 1,2,1", xOut, yOut, valid); end
        nCmp++; if (passDone !== 1'b0 || lastPoint !== 1'b0) begin nErr++; $display("FAIL ab_flags got %b%b want 00", passDone, lastPoint); end
    endtask

    task automatic test_reset_midpass();
        pulse_ld();
        pulse_ld();
        nCmp++; if (xOut !== 20'd5 || lastPoint !== 1'b1) begin nErr++; $display("FAIL rm_p2 got %0d,%b want 5,1", xOut, lastPoint); end
        rst = 1'b0;
        #1;
        nCmp++; if (xOut !== 20'd0 || yOut !== 20'd0 || count !== 8'd0) begin nErr++; $display("FAIL rm_async got %0d,%0d,%0d want 0,0,0", xOut, yOut, count); end
        nCmp++; if ({valid, lastPoint, passDone, busy} !== 4'b0) begin nErr++; $display("FAIL rm_flags got %b want 0000", {valid, lastPoint, passDone, busy}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        nCmp++; if (valid !== 1'b0 || busy !== 1'b0) begin nErr++; $display("FAIL rm_emptystart got %b%b want 00", valid, busy); end
        wrEn = 1'b1; wrX = 20'd7; wrY = 20'd8; passStart = 1'b1;
        @(negedge clk);
        wrEn = 1'b0; passStart = 1'b0;
        nCmp++; if (xOut !== 20'd7 || yOut !== 20'd8 || valid !== 1'b1 || lastPoint !== 1'b1) begin nErr++; $display("FAIL rm_onept got %0d,%0d,%b%b want 7,8,11", xOut, yOut, valid, lastPoint); end
        nCmp++; if (count !== 8'd1) begin nErr++; $display("FAIL rm_count got %0d want 1", count); end
        pulse_ld();
        nCmp++; if ({passDone, valid} !== 2'b10 || xOut !== 20'd7) begin nErr++; $display("FAIL rm_onedone got %b,%0d want 10,7", {passDone, valid}, xOut); end
    endtask

    task automatic test_idle_events();
        pulse_ld();
        nCmp++; if (valid !== 1'b0 || passDone !== 1'b0 || count !== 8'd1) begin nErr++; $display("FAIL ie_ldarmed got %b%b,%0d want 00,1", valid, passDone, count); end
`ifdef FEEDER_OVERRUN_CHECK_EN
        nCmp++; if (overrun !== 1'b1) begin nErr++; $display("FAIL ie_ovr_set got %b want 1", overrun); end
`endif
        pulse_clear();
        nCmp++; if (count !== 8'd0 || valid !== 1'b0) begin nErr++; $display("FAIL ie_clear got %0d,%b want 0,0", count, valid); end
`ifdef FEEDER_OVERRUN_CHECK_EN
        nCmp++; if (overrun !== 1'b0) begin nErr++; $display("FAIL ie_ovr_clr got %b want 0", overrun); end
`endif
        pulse_start();
        nCmp++; if (valid !== 1'b0 || busy !== 1'b0) begin nErr++; $display("FAIL ie_start0 got %b%b want 00", valid, busy); end
        pulse_ld();
        nCmp++; if (valid !== 1'b0 || count !== 8'd0) begin nErr++; $display("FAIL ie_ldload got %b,%0d want 0,0", valid, count); end
`ifdef FEEDER_OVERRUN_CHECK_EN
        nCmp++; if (overrun !== 1'b1) begin nErr++; $display("FAIL ie_ovr_set2 got %b want 1", overrun); end
`endif
    endtask

    task automatic test_fill();
        pulse_clear();
        for (int i = 0; i < N; i++) begin
            wrEn = 1'b1; wrX = DW'(i + 100); wrY = DW'(i * 3);
            @(negedge clk);
        end
        wrEn = 1'b0;
        nCmp++; if (full !== 1'b1 || count !== 8'd150) begin nErr++; $display("FAIL fl_full got %b,%0d want 1,150", full, count); end
        write_pt(999, 999);
        nCmp++; if (count !== 8'd150) begin nErr++; $display("FAIL fl_ignore got %0d want 150", count); end
`ifdef FEEDER_OVERRUN_CHECK_EN
        nCmp++; if (overrun !== 1'b1) begin nErr++; $display("FAIL fl_ovr got %b want 1", overrun); end
`endif
        pulse_start();
        nCmp++; if (xOut !== 20'd100 || yOut !== 20'd0 || lastPoint !== 1'b0) begin nErr++; $display("FAIL fl_p0 got %0d,%0d,%b want 100,0,0", xOut, yOut, lastPoint); end
`ifdef FEEDER_OVERRUN_CHECK_EN
        nCmp++; if (overrun !== 1'b0) begin nErr++; $display("FAIL fl_ovr_clr got %b want 0", overrun); end
`endif
        ld = 1'b1;
        repeat (N - 1) @(negedge clk);
        ld = 1'b0;
        nCmp++; if (xOut !== 20'd249 || yOut !== 20'd447 || lastPoint !== 1'b1) begin nErr++; $display("FAIL fl_last got %0d,%0d,%b want 249,447,1", xOut, yOut, lastPoint); end
        pulse_ld();
        nCmp++; if ({passDone, valid, busy} !== 3'b100) begin nErr++; $display("FAIL fl_done got %b want 100", {passDone, valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_restart_pass();
        test_abort();
        test_reset_midpass();
        test_idle_events();
        test_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
